// File: rtl/uart_alu_pkg.sv
// Shared types and helpers for the UART ALU request/response path.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_OP = 3'd1,
    LEN_LO = 3'd2,
    LEN_HI = 3'd3,
    DATA   = 3'd4,
    CKSUM  = 3'd5
  } state_t;

  typedef logic [6:0] opcode_t;

  localparam int         HDR_ERR_BIT = 7;
  localparam logic [7:0] LEN_HI_C    = 8'h00;

  function automatic logic [7:0] make_hdr(input logic err, input opcode_t opcode);
    logic [7:0] hdr;
    hdr              = {1'b0, opcode};
    hdr[HDR_ERR_BIT] = err;
    return hdr;
  endfunction

  function automatic logic [7:0] xor8(input logic [7:0] a, input logic [7:0] b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/alu_resp_framer.sv
// Serialises one ALU result into a byte packet on an AXI-stream byte master:
// header, length (lo/hi), result bytes LSB first, optional XOR checksum.
module alu_resp_framer
  import uart_alu_pkg::*;
#(
  parameter int RESULT_BYTES_P = 4,
  parameter bit CHECKSUM_EN_P  = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        res_valid_i,
  output logic                        res_ready_o,
  input  logic [6:0]                  res_opcode_i,
  input  logic                        res_err_i,
  input  logic [8*RESULT_BYTES_P-1:0] res_data_i,
  output logic [7:0]                  m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy_o
);

  localparam int                   IDX_W    = $clog2(RESULT_BYTES_P + 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(RESULT_BYTES_P - 1);
  localparam logic [7:0]           LEN_LO_C = 8'(RESULT_BYTES_P);

  state_t                      state_q, state_d;
  logic [7:0]                  tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [8*RESULT_BYTES_P-1:0] data_q, data_d, data_shr;
  logic [7:0]                  cksum_q, cksum_d;
  logic                        accept;
  logic                        capture;

  assign res_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

  assign accept  = tvalid_q && m_axis_tready;
  assign capture = res_valid_i && res_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      cksum_q  <= '0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      cksum_q  <= cksum_d;
    end
  end

  // cksum_q always holds the XOR of every byte up to and including tdata_q,
  // so the checksum beat can be loaded straight from it.
  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    idx_d    = idx_q;
    data_d   = data_q;
    cksum_d  = cksum_q;
    data_shr = data_q >> 8;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d  = HDR_OP;
          tdata_d  = make_hdr(res_err_i, res_opcode_i);
          tvalid_d = 1'b1;
          cksum_d  = make_hdr(res_err_i, res_opcode_i);
          data_d   = res_data_i;
          idx_d    = '0;
        end
      end
      HDR_OP: begin
        if (accept) begin
          state_d = LEN_LO;
          tdata_d = LEN_LO_C;
          cksum_d = xor8(cksum_q, LEN_LO_C);
        end
      end
      LEN_LO: begin
        if (accept) begin
          state_d = LEN_HI;
          tdata_d = LEN_HI_C;
          cksum_d = xor8(cksum_q, LEN_HI_C);
        end
      end
      LEN_HI: begin
        if (accept) begin
          state_d = DATA;
          tdata_d = data_q[7:0];
          cksum_d = xor8(cksum_q, data_q[7:0]);
          idx_d   = '0;
        end
      end
      DATA: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            if (CHECKSUM_EN_P) begin
              state_d = CKSUM;
              tdata_d = cksum_q;
            end else begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            data_d  = data_shr;
            tdata_d = data_shr[7:0];
            cksum_d = xor8(cksum_q, data_shr[7:0]);
          end
        end
      end
      CKSUM: begin
        if (accept) begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_resp_framer.sv
// Directed scoreboard bench for alu_resp_framer (checksum and no-checksum builds).
module tb_alu_resp_framer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        res_valid_a, res_valid_b;
  logic        res_ready_a, res_ready_b;
  logic [6:0]  res_opcode;
  logic        res_err;
  logic [31:0] res_data;
  logic [7:0]  tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b;
  logic        tready;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] sb_q[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  alu_resp_framer #(.RESULT_BYTES_P(4), .CHECKSUM_EN_P(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .res_valid_i(res_valid_a), .res_ready_o(res_ready_a),
    .res_opcode_i(res_opcode), .res_err_i(res_err), .res_data_i(res_data),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready),
    .busy_o(busy_a)
  );

  alu_resp_framer #(.RESULT_BYTES_P(4), .CHECKSUM_EN_P(1'b0)) dut_nc (
    .clk_i(clk_i), .reset_i(reset_i),
    .res_valid_i(res_valid_b), .res_ready_o(res_ready_b),
    .res_opcode_i(res_opcode), .res_err_i(res_err), .res_data_i(res_data),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready),
    .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input logic [6:0] op, input logic err, input logic [31:0] d,
                          input bit with_ck);
    logic [7:0] x;
    logic [7:0] b;
    b = {err, op};
    sb_q.push_back(b); x = b;
    sb_q.push_back(8'h04); x = x ^ 8'h04;
    sb_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      sb_q.push_back(b);
      x = x ^ b;
    end
    if (with_ck) sb_q.push_back(x);
  endtask

  // Called at a sample point; presents a result for exactly one edge.
  task automatic drive(input bit sel, input logic [6:0] op, input logic err,
                       input logic [31:0] d);
    res_opcode = op; res_err = err; res_data = d;
    if (sel) res_valid_b = 1'b1; else res_valid_a = 1'b1;
    push_pkt(op, err, d, !sel);
    @(posedge clk_i); #1;
    res_valid_a = 1'b0; res_valid_b = 1'b0;
    res_opcode = 7'h0; res_err = 1'b0; res_data = 32'h0;
  endtask

  // Consumes n beats from the selected DUT, optionally stalling tready at one beat.
  task automatic collect(input bit sel, input int n_beats, input int stall_beat,
                         input int stall_len, input bit chk_ready_low, input bit chk_end,
                         output int first_acc, output int last_acc);
    int beat, stall, budget;
    logic       tv, rdy;
    logic [7:0] td, exp;
    beat = 0; stall = 0; budget = 0; first_acc = -1; last_acc = -1;
    while (beat < n_beats && budget < 200) begin
      tv  = sel ? tvalid_b : tvalid_a;
      td  = sel ? tdata_b : tdata_a;
      rdy = sel ? res_ready_b : res_ready_a;
      if (tv && beat == stall_beat && stall < stall_len) begin
        tready = 1'b0;
        stall++;
        chk("stall_tdata", td, sb_q[0]);
      end else begin
        tready = 1'b1;
      end
      if (beat > 0) chk("tvalid_held", tv, 1'b1);
      if (tv && tready) begin
        exp = sb_q.pop_front();
        chk($sformatf("beat%0d", beat), td, exp);
        if (chk_ready_low) chk("ready_low", rdy, 1'b0);
        if (beat == 0) first_acc = cyc + 1;
        last_acc = cyc + 1;
        beat++;
      end
      @(posedge clk_i); #1;
      budget++;
    end
    chk("beats_done", beat, n_beats);
    tready = 1'b1;
    if (chk_end) begin
      chk("tvalid_end", sel ? tvalid_b : tvalid_a, 1'b0);
      chk("ready_end", sel ? res_ready_b : res_ready_a, 1'b1);
    end
  endtask

  initial begin
    int f1, l1, f2, l2;
    reset_i = 1'b1; res_valid_a = 1'b0; res_valid_b = 1'b0;
    res_opcode = 7'h0; res_err = 1'b0; res_data = 32'h0; tready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(posedge clk_i); #1;

    chk("rst_tvalid", tvalid_a, 1'b0);
    chk("rst_tdata", tdata_a, 8'h00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_ready", res_ready_a, 1'b1);

    // basic packet, full-rate sink
    drive(1'b0, 7'h03, 1'b0, 32'h12345678);
    chk("latency_tvalid", tvalid_a, 1'b1);
    chk("latency_busy", busy_a, 1'b1);
    collect(1'b0, 8, -1, 0, 1'b0, 1'b1, f1, l1);
    chk("consecutive", l1 - f1, 7);

    // error flag set, zero data
    drive(1'b0, 7'h05, 1'b1, 32'h0);
    collect(1'b0, 8, -1, 0, 1'b1, 1'b1, f1, l1);

    // sink stalls three cycles on byte 0x78
    drive(1'b0, 7'h03, 1'b0, 32'h12345678);
    collect(1'b0, 8, 3, 3, 1'b0, 1'b1, f1, l1);
    chk("stall_span", l1 - f1, 10);

    // back-to-back results with valid held
    res_opcode = 7'h11; res_err = 1'b0; res_data = 32'hDEADBEEF; res_valid_a = 1'b1;
    push_pkt(7'h11, 1'b0, 32'hDEADBEEF, 1'b1);
    push_pkt(7'h22, 1'b1, 32'h00FF00FF, 1'b1);
    @(posedge clk_i); #1;
    res_opcode = 7'h22; res_err = 1'b1; res_data = 32'h00FF00FF;
    collect(1'b0, 8, -1, 0, 1'b0, 1'b1, f1, l1);
    @(posedge clk_i); #1;
    res_valid_a = 1'b0;
    collect(1'b0, 8, -1, 0, 1'b0, 1'b1, f2, l2);
    chk("b2b_gap", f2 - l1, 2);

    // reset while data byte 2 is on the bus
    drive(1'b0, 7'h09, 1'b0, 32'hA5A55A5A);
    collect(1'b0, 5, -1, 0, 1'b0, 1'b0, f1, l1);
    chk("pre_rst_tdata", tdata_a, 8'hA5);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk("midrst_tvalid", tvalid_a, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    sb_q.delete();
    @(posedge clk_i); #1;
    chk("postrst_idle", tvalid_a, 1'b0);
    drive(1'b0, 7'h7F, 1'b0, 32'hCAFEF00D);
    collect(1'b0, 8, -1, 0, 1'b0, 1'b1, f1, l1);

    // build without checksum
    drive(1'b1, 7'h01, 1'b0, 32'hA1B2C3D4);
    collect(1'b1, 7, -1, 0, 1'b1, 1'b1, f1, l1);
    chk("nc_consecutive", l1 - f1, 6);
    repeat (2) @(posedge clk_i); #1;
    chk("nc_no_extra", tvalid_b, 1'b0);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
